// File: rtl/hex_display_scheduler.sv
// rtl/hex_display_scheduler.sv - round-robin sharing of the six-digit HEX bank between two requesters
// A granted value owns the display for DWELL cycles, then the bank is re-arbitrated.

module hex_digit_decoder (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Active-low segments, gfedcba order.
  always_comb begin
    seg = 7'b1111111;
    if (!blank) begin
      case (digit)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        4'hF: seg = 7'b0001110;
        default: seg = 7'b1111111;
      endcase
    end
  end

endmodule

module hex_display_scheduler #(
  parameter int DWELL = 50_000_000,
  parameter int CNT_W = $clog2(DWELL + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [23:0] data0,
  input  logic [23:0] data1,
  input  logic        lead_blank,
  output logic [1:0]  ack,
  output logic        busy,
  output logic        owner,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [23:0]        disp_q, disp_d;
  logic               blank_q, blank_d;
  logic               valid_q, valid_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [1:0]         ack_q, ack_d;
  logic               grant;
  logic               win;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      disp_q  <= '0;
      blank_q <= 1'b0;
      valid_q <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      ack_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      disp_q  <= disp_d;
      blank_q <= blank_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    disp_d  = disp_q;
    blank_d = blank_q;
    valid_d = valid_q;
    owner_d = owner_q;
    last_d  = last_q;
    ack_d   = 2'b00;
    grant   = 1'b0;
    // A lone requester wins outright; a tie goes to whoever did not win last.
    win     = (req == 2'b11) ? ~last_q : req[1];

    if ((state_q == IDLE || count_q == '0) && req != 2'b00) begin
      grant = 1'b1;
    end

    if (grant) begin
      disp_d  = win ? data1 : data0;
      blank_d = lead_blank;
      valid_d = 1'b1;
      owner_d = win;
      last_d  = win;
      ack_d   = win ? 2'b10 : 2'b01;
      count_d = CNT_W'(DWELL - 1);
      state_d = SHOW;
    end else if (state_q == SHOW) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign ack   = ack_q;
  assign busy  = (state_q == SHOW);
  assign owner = owner_q;

  // lz[k] is set when digit k and every digit above it are zero; HEX0 is always shown.
  logic [5:0] lz;
  logic [5:0] dig_blank;

  always_comb begin
    lz    = 6'b000000;
    lz[5] = blank_q && (disp_q[23:20] == 4'h0);
    for (int k = 4; k >= 1; k--) begin
      lz[k] = lz[k+1] && (disp_q[4*k +: 4] == 4'h0);
    end
    lz[0] = 1'b0;
    dig_blank = lz | {6{~valid_q}};
  end

  logic [6:0] seg [6];

  for (genvar k = 0; k < 6; k++) begin : g_dec
    hex_digit_decoder u_dec (
      .digit (disp_q[4*k +: 4]),
      .blank (dig_blank[k]),
      .seg   (seg[k])
    );
  end

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];
  assign HEX2 = seg[2];
  assign HEX3 = seg[3];
  assign HEX4 = seg[4];
  assign HEX5 = seg[5];

endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb/tb_hex_display_scheduler.sv - directed self-checking bench for hex_display_scheduler
// Expected values are hand-computed for DWELL = 4.

module tb_hex_display_scheduler;

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] G0 = 7'h40;
  localparam logic [6:0] G1 = 7'h79;
  localparam logic [6:0] G2 = 7'h24;
  localparam logic [6:0] G6 = 7'h02;
  localparam logic [6:0] GF = 7'h0E;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [23:0] data0;
  logic [23:0] data1;
  logic        lead_blank;
  logic [1:0]  ack;
  logic        busy;
  logic        owner;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int compared   = 0;
  int mismatched = 0;

  hex_display_scheduler #(.DWELL(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data0      (data0),
    .data1      (data1),
    .lead_blank (lead_blank),
    .ack        (ack),
    .busy       (busy),
    .owner      (owner),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3),
    .HEX4       (HEX4),
    .HEX5       (HEX5)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hex(input string tag, input logic [6:0] e5, input logic [6:0] e4,
                         input logic [6:0] e3, input logic [6:0] e2,
                         input logic [6:0] e1, input logic [6:0] e0);
    chk({tag, "_hex5"}, HEX5, e5);
    chk({tag, "_hex4"}, HEX4, e4);
    chk({tag, "_hex3"}, HEX3, e3);
    chk({tag, "_hex2"}, HEX2, e2);
    chk({tag, "_hex1"}, HEX1, e1);
    chk({tag, "_hex0"}, HEX0, e0);
  endtask

  initial begin
    reset = 1'b0; req = 2'b00; data0 = '0; data1 = '0; lead_blank = 1'b0;

    // Reset held for two cycles
    tick(); tick();
    chk_hex("rst", BL, BL, BL, BL, BL, BL);
    chk("rst_busy", {6'd0, busy}, 7'd0);
    chk("rst_ack", {5'd0, ack}, 7'd0);
    chk("rst_owner", {6'd0, owner}, 7'd0);

    reset = 1'b1;
    tick();
    chk("idle_busy", {6'd0, busy}, 7'd0);
    chk_hex("idle_blank", BL, BL, BL, BL, BL, BL);

    // Single grant with leading-zero blanking
    req = 2'b01; data0 = 24'h00012F; lead_blank = 1'b1;
    tick();
    chk("g1_ack", {5'd0, ack}, 7'd1);
    chk("g1_busy", {6'd0, busy}, 7'd1);
    chk("g1_owner", {6'd0, owner}, 7'd0);
    chk_hex("g1", BL, BL, BL, G1, G2, GF);
    req = 2'b00; lead_blank = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("g1_ack_low", {5'd0, ack}, 7'd0);
      chk("g1_busy_dwell", {6'd0, busy}, 7'd1);
    end
    tick();
    chk("g1_busy_end", {6'd0, busy}, 7'd0);
    chk_hex("g1_held", BL, BL, BL, G1, G2, GF);

    // Fresh reset so the first tie goes to requester 0
    reset = 1'b0; tick(); reset = 1'b1;

    // Tie held: grants alternate 0,1,0,1 every four cycles
    req = 2'b11; data0 = 24'h111111; data1 = 24'h222222; lead_blank = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i % 4 == 0)
        chk("tie_ack_grant", {5'd0, ack}, ((i / 4) % 2 == 0) ? 7'd1 : 7'd2);
      else
        chk("tie_ack_quiet", {5'd0, ack}, 7'd0);
      chk("tie_hex5", HEX5, ((i / 4) % 2 == 0) ? G1 : G2);
      chk("tie_hex0", HEX0, ((i / 4) % 2 == 0) ? G1 : G2);
      chk("tie_owner", {6'd0, owner}, ((i / 4) % 2 == 0) ? 7'd0 : 7'd1);
    end
    req = 2'b00;
    tick();
    chk("tie_idle_busy", {6'd0, busy}, 7'd0);

    // Zero value, blanked then unblanked
    req = 2'b10; data1 = 24'h000000; lead_blank = 1'b1;
    tick();
    chk("z_ack", {5'd0, ack}, 7'd2);
    chk("z_owner", {6'd0, owner}, 7'd1);
    chk_hex("zb", BL, BL, BL, BL, BL, G0);
    req = 2'b00;
    tick(); tick(); tick(); tick();
    chk("z_idle", {6'd0, busy}, 7'd0);
    req = 2'b10; lead_blank = 1'b0;
    tick();
    chk("z2_ack", {5'd0, ack}, 7'd2);
    chk_hex("znb", G0, G0, G0, G0, G0, G0);
    req = 2'b00;
    tick(); tick(); tick(); tick();
    chk("z2_idle", {6'd0, busy}, 7'd0);

    // Request from requester 1 during requester 0's dwell is ignored
    req = 2'b01; data0 = 24'h123456;
    tick();
    chk("ign_ack0", {5'd0, ack}, 7'd1);
    chk("ign_owner0", {6'd0, owner}, 7'd0);
    chk("ign_hex0", HEX0, G6);
    chk("ign_hex5", HEX5, G1);
    req = 2'b00;
    tick();
    req = 2'b10;
    tick();
    chk("ign_ack_pulse", {5'd0, ack}, 7'd0);
    chk("ign_owner_pulse", {6'd0, owner}, 7'd0);
    req = 2'b00;
    tick();
    chk("ign_ack_after", {5'd0, ack}, 7'd0);
    tick();
    chk("ign_ack_end", {5'd0, ack}, 7'd0);
    chk("ign_owner_end", {6'd0, owner}, 7'd0);
    chk("ign_busy_end", {6'd0, busy}, 7'd0);

    // Reset mid-dwell blanks immediately; next request is granted afterwards
    req = 2'b01;
    tick();
    chk("mr_ack", {5'd0, ack}, 7'd1);
    req = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    chk_hex("mr", BL, BL, BL, BL, BL, BL);
    chk("mr_busy", {6'd0, busy}, 7'd0);
    chk("mr_ack_clr", {5'd0, ack}, 7'd0);
    reset = 1'b1; req = 2'b01;
    tick();
    chk("mr_regrant_ack", {5'd0, ack}, 7'd1);
    chk("mr_regrant_busy", {6'd0, busy}, 7'd1);
    chk("mr_regrant_hex0", HEX0, G6);
    req = 2'b00;
    tick(); tick(); tick(); tick();
    chk("mr_final_idle", {6'd0, busy}, 7'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hex_display_scheduler.md
# hex_display_scheduler

Shares the six-digit HEX display bank between two requesters. Each requester presents a 24-bit value (six 4-bit digits) and a request. The block grants the display round-robin and latches the winner's value. It holds that value on HEX5..HEX0 for a fixed dwell time, with optional leading-zero blanking, and then re-arbitrates. It sits between the lab's data-producing blocks (e.g. address/data viewers) and the per-digit hex decoder instances, which it instantiates internally, one per display.

## Interface

Parameters:
- DWELL, default 50_000_000: cycles a granted value owns the display; legal range ≥ 1.
- CNT_W, default $clog2(DWELL+1): dwell counter width; derived, not overridden.

Ports:
- clk  in  1: system clock; all state on rising edge.
- reset  in  1: synchronous, active-low reset; sampled on rising edge of clk.
- req  in  2: req[i] high = requester i wants the display; level-sensitive.
- data0  in  24: requester 0 digits; [23:20] → HEX5 … [3:0] → HEX0.
- data1  in  24: requester 1 digits, same mapping.
- lead_blank  in  1: sampled at grant; 1 = suppress leading zero digits.
- ack  out  2: one-cycle pulse on bit i when requester i's data is latched.
- busy  out  1: high while in SHOW.
- owner  out  1: index of the most recently granted requester.
- HEX0..HEX5  out  7 each: active-low segment patterns, gfedcba order.

## Operation

- Two states:
  - IDLE: no dwell in progress; display holds the last latched value.
  - SHOW: dwell counter running.
- Arbitration happens on any edge where (state == IDLE, or state == SHOW with count == 0) and req != 0:
  - One requester pending: it wins.
  - Both pending: winner = ~last_owner (round-robin).
  - last_owner resets to 1, so requester 0 wins the first tie.
- On a grant edge:
  - Latch data_w into disp_reg and lead_blank into blank_reg.
  - owner ← w; ack[w] ← 1 (all other ack bits 0).
  - count ← DWELL-1; state ← SHOW.
- SHOW with count > 0: count decrements by 1 per cycle; req is ignored; ack = 0.
- SHOW with count == 0:
  - If req != 0: grant immediately, back-to-back per the rules above.
  - Otherwise: state ← IDLE and busy ← 0; the display keeps its value.
- A req that drops before its grant edge is never served; there is no request memory.
- Requester held high continuously with no competitor: re-granted every DWELL cycles, with an ack pulse each time.
- Both requesters held high continuously: grants alternate 0,1,0,1…
- Display decode:
  - Each HEXk = decode(disp_reg[4k+3:4k]) with the 0–F hex glyph set.
  - A blanked digit drives 7'b1111111.
- Leading-zero blanking (blank_reg = 1):
  - Scan HEX5 down to HEX1; blank each digit that is 0 and has all higher digits 0.
  - Stop at the first nonzero digit.
  - HEX0 is never blanked, so value 0 shows a single "0" on HEX0.
- Before the first grant after reset, all six displays are blank (blank_valid = 0 forces 7'b1111111).

## Timing

- Reset values (reset = 0 at an edge):
  - state = IDLE, busy = 0, ack = 2'b00, owner = 0.
  - last_owner = 1, count = 0, disp_reg = 0, blank_reg = 0, blank_valid = 0.
  - HEX0..HEX5 = 7'b1111111.
- Reset asserted mid-SHOW: takes effect at that edge; displays blank the same cycle after the edge, and any pending ack is cleared.
- Request-to-display latency:
  - req sampled high at edge E in IDLE → ack, owner, busy and disp_reg update at E.
  - HEX outputs are combinational from registers, so they are valid after E (1-cycle latency).
- Dwell: the grant at edge E allows the next grant no earlier than edge E+DWELL. busy stays high for exactly DWELL cycles when no further request arrives.
- DWELL = 1: count loads 0, so back-to-back grants can occur every cycle.
- ack is never high for two consecutive cycles to the same requester unless DWELL = 1.
- Count never underflows: decrement only when count > 0.

## Test plan

All scenarios use DWELL = 4.

- Reset: hold reset = 0 for 2 cycles → HEX0..5 = 7'h7F, busy = 0, ack = 0, owner = 0.
- Single grant with blanking: req = 01, data0 = 24'h00012F, lead_blank = 1 for 1 cycle → ack = 01 one cycle.
  - HEX5..HEX3 = 7'h7F; HEX2 = "1", HEX1 = "2", HEX0 = "F".
  - busy high for 4 cycles, then IDLE with the display held.
- Tie and alternation: req = 11 held, data0 = 24'h111111, data1 = 24'h222222 → acks at cycles 0, 4, 8, 12 to requesters 0, 1, 0, 1; display alternates all-1s and all-2s.
- Zero value: data1 = 0, lead_blank = 1 → HEX5..HEX1 blank, HEX0 = 7'b1000000. With lead_blank = 0 → all six show "0".
- Request ignored during SHOW: grant req0, pulse req1 for 1 cycle at dwell cycle 2 → no ack[1], owner stays 0.
- Mid-SHOW reset: during dwell cycle 2, reset = 0 for 1 cycle → all HEX = 7'h7F and busy = 0 next cycle; a new req0 is granted on the following edge.
